// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/result bundle between the execute stage and the divider
interface divider_if #(
    parameter int DIV_WIDTH = 32
);
    logic                 div;
    logic                 div_signed;
    logic                 cancel;
    logic [DIV_WIDTH-1:0] x;
    logic [DIV_WIDTH-1:0] y;
    logic                 busy;
    logic                 complete;
    logic [DIV_WIDTH-1:0] s;
    logic [DIV_WIDTH-1:0] r;

    modport master (
        output div, div_signed, cancel, x, y,
        input  busy, complete, s, r
    );

    modport slave (
        input  div, div_signed, cancel, x, y,
        output busy, complete, s, r
    );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider for MIPS DIV/DIVU (quotient on s, remainder on r)
// Optional DIV_SHORTCUT_EN: |x| < |y| skips the magnitude loop and goes straight to FIX.
module divider #(
    parameter int DIV_WIDTH = 32
) (
    input logic      div_clk,
    input logic      rst,
    divider_if.slave bus
);
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0] dsr_q, dsr_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] s_q, s_d;
    logic [DIV_WIDTH-1:0] r_q, r_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 busy_q, busy_d;
    logic                 complete_q, complete_d;

    logic [DIV_WIDTH-1:0] abs_x;
    logic [DIV_WIDTH-1:0] abs_y;
    logic [DIV_WIDTH:0]   rem_wide;
    logic                 rem_ge;
    logic [DIV_WIDTH-1:0] rem_sub;

    always_comb begin
        abs_x = (bus.div_signed && bus.x[DIV_WIDTH-1]) ? -bus.x : bus.x;
        abs_y = (bus.div_signed && bus.y[DIV_WIDTH-1]) ? -bus.y : bus.y;

        // The shifted remainder needs one extra bit; once it is >= the divisor
        // the true difference fits in DIV_WIDTH bits, so a narrow subtract suffices.
        rem_wide = {rem_q, dvd_q[DIV_WIDTH-1]};
        rem_ge   = rem_wide >= {1'b0, dsr_q};
        rem_sub  = rem_wide[DIV_WIDTH-1:0] - dsr_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        s_d        = s_q;
        r_d        = r_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        complete_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.div && !bus.cancel) begin
                    dvd_d   = abs_x;
                    dsr_d   = abs_y;
                    qneg_d  = bus.div_signed & (bus.x[DIV_WIDTH-1] ^ bus.y[DIV_WIDTH-1]);
                    rneg_d  = bus.div_signed & bus.x[DIV_WIDTH-1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_SHORTCUT_EN
                    if (abs_x < abs_y) begin
                        rem_d   = abs_x;
                        state_d = S_FIX;
                    end
`endif
                end
            end

            S_CALC: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_ge ? rem_sub : rem_wide[DIV_WIDTH-1:0];
                    quo_d = {quo_q[DIV_WIDTH-2:0], rem_ge};
                    dvd_d = {dvd_q[DIV_WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIV_WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.cancel) begin
                    s_d        = qneg_q ? -quo_q : quo_q;
                    r_d        = rneg_q ? -rem_q : rem_q;
                    complete_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            s_q        <= s_d;
            r_q        <= r_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.complete = complete_q;
    assign bus.s        = s_q;
    assign bus.r        = r_q;
endmodule
